uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BIT_RATE, default 9600, serial bit rate in bits/s.
REQ-003 Parameter PAYLOAD_BITS, default 8, data bits per frame.
REQ-004 Derived constants SHALL be CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer divide) and HALF_BIT = CYCLES_PER_BIT/2.
REQ-005 Port clk, input, 1, single system clock; all state on rising edge.
REQ-006 Port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Port uart_rxd, input, 1, asynchronous serial line, idle high.
REQ-008 Port uart_rx_en, input, 1, receiver enable; low holds the receiver idle.
REQ-009 Port uart_rx_data, output, PAYLOAD_BITS, last correctly framed byte.
REQ-010 Port uart_rx_valid, output, 1, one-cycle pulse: new byte on uart_rx_data.
REQ-011 Port uart_rx_frame_err, output, 1, one-cycle pulse: stop bit sampled low.
REQ-012 Port uart_rx_busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 uart_rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rxd_s); 2 cycles of input latency.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, BREAK_WAIT.
REQ-015 IDLE: on rxd_s == 0 with uart_rx_en == 1 -> START, bit-cycle counter cleared.
REQ-016 START: count HALF_BIT cycles, then resample; rxd_s == 0 -> DATA (counter cleared, bit index 0); rxd_s == 1 -> IDLE, glitch rejected, no output pulse.
REQ-017 DATA: every CYCLES_PER_BIT cycles sample rxd_s into a shift register, LSB first; after bit PAYLOAD_BITS-1 -> STOP.
REQ-018 STOP: after CYCLES_PER_BIT cycles sample rxd_s; 1 -> load uart_rx_data from shift register, pulse uart_rx_valid, -> IDLE; 0 -> pulse uart_rx_frame_err, uart_rx_data unchanged, -> BREAK_WAIT.
REQ-019 uart_rx_valid and uart_rx_frame_err SHALL assert on the cycle following the stop-bit sample, for exactly one cycle, never simultaneously.
REQ-020 BREAK_WAIT: remain until rxd_s == 1, then -> IDLE; no new start detected while line held low.
REQ-021 uart_rx_data SHALL hold its value between valid pulses; it changes only on the valid cycle.
REQ-022 uart_rx_en deasserted in any non-IDLE state: abort to IDLE on next clock edge, no valid or frame_err pulse, uart_rx_data unchanged.
REQ-023 Back-to-back frames: a start edge seen in IDLE on the cycle after STOP SHALL be accepted (zero idle bits between frames tolerated beyond the half stop bit remaining).
REQ-024 Bit-cycle counter width SHALL be ceil(log2(CYCLES_PER_BIT+1)); bit index width ceil(log2(PAYLOAD_BITS+1)); no wrap within a frame.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, counters 0, shift register 0, uart_rx_data 0, uart_rx_valid 0, uart_rx_frame_err 0, uart_rx_busy 0, synchronizer flops 1.
REQ-026 Reset asserted mid-frame SHALL discard the partial byte; after release the receiver waits for a fresh falling edge.

Verification (CLK_HZ=1_000_000, BIT_RATE=100_000 -> 10 cycles/bit, HALF_BIT=5)
REQ-027 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> single uart_rx_valid pulse, uart_rx_data = 0xA5, frame_err never high.
REQ-028 3-cycle low glitch on idle line -> state returns IDLE, no valid, no frame_err, uart_rx_data unchanged.
REQ-029 Frame 0x3C with stop bit 0, line held low 30 cycles -> one frame_err pulse, data keeps prior 0xA5, busy high until line returns high.
REQ-030 Frames 0x00 then 0xFF with no idle gap -> two valid pulses, data 0x00 then 0xFF.
REQ-031 uart_rx_en dropped during bit 4 of 0x55 -> busy low next cycle, no pulses; following frame 0x81 with en high -> data 0x81.
REQ-032 reset_n pulsed low during bit 2 of a frame -> all outputs 0 immediately; next full frame 0x7E received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// Purpose: UART receiver, LSB-first payload, 1 start and 1 stop bit, mid-bit sampling.
// Latency: valid or frame_err pulses one cycle after the stop-bit sample (2-flop input sync ahead of that).
// Backpressure: none; the consumer must take uart_rx_data on the valid pulse. uart_rx_en low aborts to IDLE.
module uart_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_busy
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam int IDX_W          = $clog2(PAYLOAD_BITS + 1);

  // Terminal counts: the counter starts at 0 on entry, so N cycles end at N-1.
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } state_t;

  state_t                  state_q;
  logic                    rxd_meta_q;
  logic                    rxd_s_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic [PAYLOAD_BITS-1:0] data_q;
  logic                    valid_q;
  logic                    ferr_q;

  // Two-flop synchronizer on the serial line; resets to the idle (high) level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Frame FSM: start qualification at half bit, then one sample per bit period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (state_q != IDLE && !uart_rx_en) begin
        // Disable mid-frame drops the partial byte silently.
        state_q <= IDLE;
        cnt_q   <= '0;
        idx_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (uart_rx_en && !rxd_s_q) begin
              state_q <= START;
              cnt_q   <= '0;
            end
          end
          START: begin
            if (cnt_q == CNT_HALF) begin
              cnt_q <= '0;
              if (!rxd_s_q) begin
                state_q <= DATA;
                idx_q   <= '0;
              end else begin
                // Line went back high before mid start bit: treat as glitch.
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DATA: begin
            if (cnt_q == CNT_FULL) begin
              cnt_q   <= '0;
              shift_q <= {rxd_s_q, shift_q[PAYLOAD_BITS-1:1]};
              if (idx_q == IDX_LAST) begin
                state_q <= STOP;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          STOP: begin
            if (cnt_q == CNT_FULL) begin
              cnt_q <= '0;
              if (rxd_s_q) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                state_q <= IDLE;
              end else begin
                // Low stop bit: report and wait out a possible break.
                ferr_q  <= 1'b1;
                state_q <= BREAK_WAIT;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          BREAK_WAIT: begin
            if (rxd_s_q) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_valid     = valid_q;
  assign uart_rx_frame_err = ferr_q;
  assign uart_rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: self-checking bench for uart_rx at 10 cycles per bit.
// Latency: expects each data pulse within the stop bit of the frame that produced it.
// Backpressure: none; expected bytes are queued at send time and popped on each valid pulse.
module tb_uart_rx;

  logic       clk;
  logic       reset_n;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_frame_err;
  logic       uart_rx_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_HZ      (1_000_000),
    .BIT_RATE    (100_000),
    .PAYLOAD_BITS(8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .uart_rxd         (uart_rxd),
    .uart_rx_en       (uart_rx_en),
    .uart_rx_data     (uart_rx_data),
    .uart_rx_valid    (uart_rx_valid),
    .uart_rx_frame_err(uart_rx_frame_err),
    .uart_rx_busy     (uart_rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every valid pulse pops the oldest expected byte.
  always @(negedge clk) begin
    if (reset_n) begin
      if (uart_rx_frame_err) n_ferr++;
      if (uart_rx_valid) begin
        n_valid++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_valid: got data %02h, no byte expected", uart_rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (uart_rx_data !== e || uart_rx_frame_err !== 1'b0)
            $display("FAIL rx_byte: got data %02h ferr %b, expected %02h ferr 0",
                     uart_rx_data, uart_rx_frame_err, e);
          else
            n_pass++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    uart_rxd = 1'b0;
    idle(10);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      idle(10);
    end
    uart_rxd = stop_b;
    idle(10);
  endtask

  task automatic test_reset;
    reset_n    = 1'b0;
    uart_rxd   = 1'b1;
    uart_rx_en = 1'b1;
    idle(3);
    n_checks++; if (uart_rx_data !== 8'h00) $display("FAIL reset_data: got %02h, expected 00", uart_rx_data); else n_pass++;
    n_checks++; if (uart_rx_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", uart_rx_valid); else n_pass++;
    n_checks++; if (uart_rx_frame_err !== 1'b0) $display("FAIL reset_ferr: got %b, expected 0", uart_rx_frame_err); else n_pass++;
    n_checks++; if (uart_rx_busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", uart_rx_busy); else n_pass++;
    reset_n = 1'b1;
    idle(5);
  endtask

  task automatic test_single_frame;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(5);
    n_checks++; if (n_valid - v0 !== 1) $display("FAIL a5_valid_count: got %0d, expected 1", n_valid - v0); else n_pass++;
    n_checks++; if (n_ferr - f0 !== 0) $display("FAIL a5_ferr_count: got %0d, expected 0", n_ferr - f0); else n_pass++;
    n_checks++; if (uart_rx_data !== 8'hA5) $display("FAIL a5_data_hold: got %02h, expected a5", uart_rx_data); else n_pass++;
    n_checks++; if (uart_rx_busy !== 1'b0) $display("FAIL a5_busy_after: got %b, expected 0", uart_rx_busy); else n_pass++;
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    uart_rxd = 1'b0;
    idle(3);
    n_checks++; if (uart_rx_busy !== 1'b1) $display("FAIL glitch_busy_seen: got %b, expected 1", uart_rx_busy); else n_pass++;
    uart_rxd = 1'b1;
    idle(20);
    n_checks++; if (uart_rx_busy !== 1'b0) $display("FAIL glitch_idle: busy %b, expected 0", uart_rx_busy); else n_pass++;
    n_checks++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0)
      $display("FAIL glitch_pulses: valid %0d ferr %0d, expected 0 0", n_valid - v0, n_ferr - f0); else n_pass++;
    n_checks++; if (uart_rx_data !== 8'hA5) $display("FAIL glitch_data: got %02h, expected a5", uart_rx_data); else n_pass++;
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    idle(20);
    n_checks++; if (n_ferr - f0 !== 1) $display("FAIL ferr_count: got %0d, expected 1", n_ferr - f0); else n_pass++;
    n_checks++; if (n_valid - v0 !== 0) $display("FAIL ferr_valid_count: got %0d, expected 0", n_valid - v0); else n_pass++;
    n_checks++; if (uart_rx_data !== 8'hA5) $display("FAIL ferr_data: got %02h, expected a5", uart_rx_data); else n_pass++;
    n_checks++; if (uart_rx_busy !== 1'b1) $display("FAIL ferr_busy_break: got %b, expected 1", uart_rx_busy); else n_pass++;
    uart_rxd = 1'b1;
    idle(5);
    n_checks++; if (uart_rx_busy !== 1'b0) $display("FAIL ferr_busy_release: got %b, expected 0", uart_rx_busy); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(5);
    n_checks++; if (n_valid - v0 !== 2) $display("FAIL b2b_valid_count: got %0d, expected 2", n_valid - v0); else n_pass++;
    n_checks++; if (uart_rx_data !== 8'hFF) $display("FAIL b2b_data: got %02h, expected ff", uart_rx_data); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL b2b_queue: %0d left, expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_enable_abort;
    logic [7:0] d;
    int v0, f0;
    d = 8'h55;
    v0 = n_valid; f0 = n_ferr;
    uart_rxd = 1'b0;
    idle(10);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = d[i];
      idle(10);
    end
    uart_rxd = d[4];
    idle(5);
    uart_rx_en = 1'b0;
    idle(1);
    n_checks++; if (uart_rx_busy !== 1'b0) $display("FAIL en_abort_busy: got %b, expected 0", uart_rx_busy); else n_pass++;
    idle(4);
    for (int i = 5; i < 8; i++) begin
      uart_rxd = d[i];
      idle(10);
    end
    uart_rxd = 1'b1;
    idle(10);
    uart_rx_en = 1'b1;
    idle(5);
    n_checks++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0)
      $display("FAIL en_abort_pulses: valid %0d ferr %0d, expected 0 0", n_valid - v0, n_ferr - f0); else n_pass++;
    n_checks++; if (uart_rx_data !== 8'hFF) $display("FAIL en_abort_data: got %02h, expected ff", uart_rx_data); else n_pass++;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(5);
    n_checks++; if (uart_rx_data !== 8'h81) $display("FAIL en_after_data: got %02h, expected 81", uart_rx_data); else n_pass++;
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    int v0;
    d = 8'h7E;
    uart_rxd = 1'b0;
    idle(10);
    for (int i = 0; i < 2; i++) begin
      uart_rxd = d[i];
      idle(10);
    end
    uart_rxd = d[2];
    idle(5);
    reset_n = 1'b0;
    #1;
    n_checks++; if (uart_rx_data !== 8'h00 || uart_rx_valid !== 1'b0 || uart_rx_frame_err !== 1'b0 || uart_rx_busy !== 1'b0)
      $display("FAIL midreset_outputs: data %02h valid %b ferr %b busy %b, expected 00 0 0 0",
               uart_rx_data, uart_rx_valid, uart_rx_frame_err, uart_rx_busy); else n_pass++;
    uart_rxd = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(20);
    v0 = n_valid;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(5);
    n_checks++; if (n_valid - v0 !== 1) $display("FAIL midreset_valid_count: got %0d, expected 1", n_valid - v0); else n_pass++;
    n_checks++; if (uart_rx_data !== 8'h7E) $display("FAIL midreset_data: got %02h, expected 7e", uart_rx_data); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL final_queue: %0d left, expected 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    reset_n    = 1'b0;
    uart_rxd   = 1'b1;
    uart_rx_en = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_enable_abort();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
